// File: rtl/common_pkg.sv
// Shared constants and helpers for the NoC link blocks.
// Imported by the arbiter front-end and its sub-modules.
package common_pkg;

  localparam int DEFAULT_D_W = 32;

  function automatic int cred_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// Round-robin grant picker: first valid request at or after ptr.
// Pure combinational; grant is suppressed when en is low.
module noc_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] sel;
  int               j;

  // Scan requesters in cyclic order starting at the pointer
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sel     = '0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (en && !found && req[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_pipe_arb.sv
// Shares one noc_pipe link among NUM_REQ single-flit senders.
// RR arbitration with burst cap, credit admission, 1-deep output reg.
module noc_pipe_arb
  import common_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int A_W       = 2,
  parameter int D_W       = DEFAULT_D_W,
  parameter int CREDITS   = 16,
  parameter int MAX_BURST = 4,
  localparam int SRC_W = $clog2(NUM_REQ),
  localparam int CNT_W = cred_w(CREDITS),
  localparam int BST_W = $clog2(MAX_BURST + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_addr,
  input  logic [NUM_REQ*D_W-1:0] req_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [A_W-1:0]         out_addr,
  output logic [D_W-1:0]         out_data,
  output logic [SRC_W-1:0]       out_src,
  input  logic                   credit_return,
  output logic [CNT_W-1:0]       credit_count,
  output logic                   credit_err
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             state;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   last_gnt;
  logic [SRC_W-1:0]   gnt_idx;
  logic [SRC_W-1:0]   ptr_inc;
  logic [BST_W-1:0]   burst;
  logic [BST_W-1:0]   burst_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic               accept;
  logic               others;
  logic               cap_hit;
  logic [A_W-1:0]     sel_addr;
  logic [D_W-1:0]     sel_data;

  // Reset gates accept so no grant leaks out while rst is low
  assign accept = rst
               && (state == EMPTY || out_ready)
               && (credit_count != '0)
               && (|req_valid);

  noc_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign others    = |(req_valid & ~gnt);

  assign ptr_inc = (gnt_idx == SRC_W'(NUM_REQ - 1))
                 ? '0 : gnt_idx + 1'b1;

  // Burst length seen so far including the current grant
  always_comb begin
    burst_nxt = BST_W'(1);
    if (gnt_idx == last_gnt && others) burst_nxt = burst + 1'b1;
    cap_hit = others && (burst_nxt >= BST_W'(MAX_BURST));
  end

  // Mux the granted requester's flit
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*A_W +: A_W];
        sel_data = req_data[i*D_W +: D_W];
      end
    end
  end

  // Pointer, previous grant and burst count advance only on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      last_gnt <= '0;
      burst    <= '0;
    end else if (accept) begin
      last_gnt <= gnt_idx;
      if (cap_hit) begin
        ptr   <= ptr_inc;
        burst <= '0;
      end else begin
        ptr   <= gnt_idx;
        burst <= burst_nxt;
      end
    end
  end

  // Credit counter with saturation and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_count <= CNT_W'(CREDITS);
      credit_err   <= 1'b0;
    end else begin
      if (credit_return && credit_count == CNT_W'(CREDITS))
        credit_err <= 1'b1;
      if (accept && !credit_return)
        credit_count <= credit_count - 1'b1;
      else if (!accept && credit_return
               && credit_count != CNT_W'(CREDITS))
        credit_count <= credit_count + 1'b1;
    end
  end

  // Output register FSM: capture on accept, drain on out_ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_addr  <= sel_addr;
            out_data  <= sel_data;
            out_src   <= gnt_idx;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) begin
              out_addr <= sel_addr;
              out_data <= sel_data;
              out_src  <= gnt_idx;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
